pwm_duty_ctrl: RTL
==================

Name: pwm_duty_ctrl

Overview:
- Consumes the debounced push-button levels produced by the debouncer stage (one debouncer instance per button).
- Turns "increase" and "decrease" presses into a saturating duty-cycle register, with auto-repeat while a button is held.
- Drives a glitch-free PWM output from that duty value.
- Sits between the debounced button inputs and the LED/motor PWM pin in the 04_PWM design.

Parameters:
- PERIOD, 1000: PWM period in clk cycles. Duty range is 0..PERIOD.
- STEP, 100: duty change per press or repeat tick.
- HOLD_CYCLES, 50_000_000: cycles a button must stay held before auto-repeat starts.
- REPEAT_CYCLES, 10_000_000: cycles between auto-repeat steps.
- DW, $clog2(PERIOD+1): width of the duty and PWM counter (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- inc_in  in  1  debounced "increase" level, already synchronous to clk
- dec_in  in  1  debounced "decrease" level, already synchronous to clk
- pwm_out  out  1  registered PWM output
- duty  out  DW  current duty register
- at_max  out  1  duty == PERIOD
- at_min  out  1  duty == 0

Behaviour:
- Reset (rst=0, async): every register clears immediately.
  - duty=0, active (shadow) duty=0, PWM counter=0, pwm_out=0, FSM=IDLE, hold counter=0, edge registers=0.
  - Hence at_min=1, at_max=0.
- Edge detect: inc_prev/dec_prev register the inputs each cycle. A rise is input=1 while prev=0.
- FSM states: IDLE, PRESS, REPEAT. The active button (INC/DEC) is latched on leaving IDLE.
- IDLE:
  - Exactly one rise: apply one step on that same edge, latch active button, clear hold counter, go to PRESS.
  - Latency: duty changes on the first edge at which the input is sampled 1.
  - Both rise in the same cycle: ignored, stay IDLE.
- PRESS:
  - Active button low: go to IDLE, no step.
  - Otherwise increment hold counter. At HOLD_CYCLES-1: apply step, clear counter, go to REPEAT.
- REPEAT:
  - Active button low: go to IDLE.
  - Otherwise step every REPEAT_CYCLES cycles (counter reaches REPEAT_CYCLES-1 -> step, clear).
- Non-active button in PRESS/REPEAT: ignored entirely.
  - A re-press after returning to IDLE needs a fresh rise; a level already high does not count.
- Step arithmetic, saturating, no wrap:
  - inc: duty = (PERIOD - duty < STEP) ? PERIOD : duty + STEP.
  - dec: duty = (duty < STEP) ? 0 : duty - STEP.
  - Compare before add/subtract so there is no overflow at DW bits.
- PWM counter:
  - Counts 0..PERIOD-1 and wraps to 0.
  - The shadow duty loads from duty only on the edge where the counter wraps (counter==PERIOD-1), so a period is never truncated.
  - pwm_out is registered as (counter < shadow).
  - Duty 0 gives a constant 0; duty PERIOD gives a constant 1.
- Flags: at_max and at_min are combinational from the duty register.
- Reset mid-repeat or mid-period: outputs return to reset values asynchronously. After release, the FSM requires a new rise.

Decomposition:
- Shared package pwm_pkg:
  - FSM state encodings (IDLE/PRESS/REPEAT).
  - Button-select encoding (BTN_INC/BTN_DEC).
  - Default PERIOD/STEP constants, shared with the debouncer top level.
- One natural sub-module, pwm_gen: PWM counter, shadow register and compare. Parameter PERIOD; ports clk, rst, duty in, pwm_out.
- pwm_duty_ctrl holds the edge detect, FSM, hold/repeat counter and duty arithmetic.

Test Plan:
Bench overrides PERIOD=10, STEP=3, HOLD_CYCLES=8, REPEAT_CYCLES=4.
1. Assert rst=0 mid-run for 2 cycles -> duty=0, pwm_out=0, at_min=1, at_max=0 immediately, before any clk edge.
2. inc_in high 3 cycles then low -> duty 0->3 on the first sampled edge, no further change. After the next counter wrap, pwm_out is high for exactly 3 of every 10 cycles.
3. Four separate inc presses from 0 -> duty 3,6,9,10; at_max=1. A fifth press keeps 10 and pwm_out stays constant 1 after the wrap.
4. From duty=10, hold dec_in for 30 cycles -> step at press (7), after 8 held cycles (4), then every 4 cycles (1, 0). Duty stays 0 and at_min=1.
5. inc_in and dec_in rise in the same cycle -> no duty change. Then inc held and dec pressed during PRESS -> only inc steps are applied.
6. Change duty 3->6 when the counter is at 5 -> the current period still outputs 3 high cycles; the next period outputs 6.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-control path.
//   state_e : duty FSM states (idle, first press, auto-repeat)
//   btn_e   : which button owns the current press
//   Default* : default PWM period / step, also used by the debouncer top level
package pwm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StRepeat
    } state_e;

    typedef enum logic {
        BtnInc,
        BtnDec
    } btn_e;

    localparam int unsigned DefaultPeriod = 1000;
    localparam int unsigned DefaultStep   = 100;

endpackage

// File: rtl/pwm_gen.sv
// PWM generator: free-running period counter, shadow duty register and
// registered compare.
//   clk     : system clock
//   rst     : asynchronous reset, active-low
//   duty    : requested duty (0..PERIOD), sampled only at the period wrap
//   pwm_out : registered PWM output, high while counter < shadow duty
module pwm_gen
    import pwm_pkg::*;
#(
    parameter  int unsigned PERIOD = DefaultPeriod,
    localparam int unsigned DW     = $clog2(PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] duty,
    output logic          pwm_out
);

    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_shadow;
    logic          r_pwm;
    logic          w_wrap;

    assign w_wrap = (r_cnt == DW'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            r_pwm    <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            // Duty only takes effect at the wrap so a period is never cut short.
            if (w_wrap) begin
                r_shadow <= duty;
            end
            r_pwm <= (r_cnt < r_shadow);
        end
    end

    assign pwm_out = r_pwm;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Push-button duty controller: edge-detects the debounced inc/dec levels,
// steps a saturating duty register on each press and auto-repeats while a
// button is held, then drives a glitch-free PWM from that duty.
//   clk     : system clock
//   rst     : asynchronous reset, active-low
//   inc_in  : debounced "increase" level (synchronous to clk)
//   dec_in  : debounced "decrease" level (synchronous to clk)
//   pwm_out : registered PWM output
//   duty    : current duty register
//   at_max  : duty == PERIOD
//   at_min  : duty == 0
module pwm_duty_ctrl
    import pwm_pkg::*;
#(
    parameter  int unsigned PERIOD        = DefaultPeriod,
    parameter  int unsigned STEP          = DefaultStep,
    parameter  int unsigned HOLD_CYCLES   = 50_000_000,
    parameter  int unsigned REPEAT_CYCLES = 10_000_000,
    localparam int unsigned DW            = $clog2(PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_in,
    input  logic          dec_in,
    output logic          pwm_out,
    output logic [DW-1:0] duty,
    output logic          at_max,
    output logic          at_min
);

    localparam int unsigned CntMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    state_e        r_state, w_state_nxt;
    btn_e          r_btn, w_btn_nxt, w_step_btn;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [DW-1:0] r_duty, w_duty_nxt;
    logic          r_inc_prev, r_dec_prev;
    logic          w_inc_rise, w_dec_rise, w_active, w_step;
    logic [DW-1:0] w_inc_val, w_dec_val;

    assign w_inc_rise = inc_in & ~r_inc_prev;
    assign w_dec_rise = dec_in & ~r_dec_prev;
    assign w_active   = (r_btn == BtnInc) ? inc_in : dec_in;

    // Compare before add/subtract so the DW-bit result can never wrap.
    assign w_inc_val = ((PERIOD - 32'(r_duty)) < STEP) ? DW'(PERIOD) : r_duty + DW'(STEP);
    assign w_dec_val = (32'(r_duty) < STEP) ? '0 : r_duty - DW'(STEP);

    always_comb begin
        w_state_nxt = r_state;
        w_btn_nxt   = r_btn;
        w_cnt_nxt   = r_cnt;
        w_step      = 1'b0;
        w_step_btn  = r_btn;
        unique case (r_state)
            StIdle: begin
                // Simultaneous rises are ambiguous and therefore ignored.
                if (w_inc_rise ^ w_dec_rise) begin
                    w_step      = 1'b1;
                    w_step_btn  = w_inc_rise ? BtnInc : BtnDec;
                    w_btn_nxt   = w_step_btn;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StPress;
                end
            end
            StPress: begin
                if (!w_active) begin
                    w_state_nxt = StIdle;
                end else if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                    w_step      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StRepeat;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StRepeat: begin
                if (!w_active) begin
                    w_state_nxt = StIdle;
                end else if (r_cnt == CW'(REPEAT_CYCLES - 1)) begin
                    w_step    = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        w_duty_nxt = r_duty;
        if (w_step) begin
            w_duty_nxt = (w_step_btn == BtnInc) ? w_inc_val : w_dec_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_btn      <= BtnInc;
            r_cnt      <= '0;
            r_duty     <= '0;
            r_inc_prev <= 1'b0;
            r_dec_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_btn      <= w_btn_nxt;
            r_cnt      <= w_cnt_nxt;
            r_duty     <= w_duty_nxt;
            r_inc_prev <= inc_in;
            r_dec_prev <= dec_in;
        end
    end

    pwm_gen #(
        .PERIOD (PERIOD)
    ) u_pwm_gen (
        .clk     (clk),
        .rst     (rst),
        .duty    (r_duty),
        .pwm_out (pwm_out)
    );

    assign duty   = r_duty;
    assign at_max = (r_duty == DW'(PERIOD));
    assign at_min = (r_duty == '0);

endmodule
